// File: rtl/role_pkg.sv
// role_pkg: shared constants and types for the player/enemy sprite pipeline
// Holds screen geometry, sprite size, the collision FSM state encoding,
// the transparent colour key and the enemy speed-offset ceiling.
package role_pkg;
    localparam int MAX_X = 640;
    localparam int MAX_Y = 480;
    localparam int SPRITE_W = 32;
    localparam int SPEED_MAX = 2000000;
    localparam logic [11:0] TRANSPARENT = 12'b000111110000;
    typedef enum logic [1:0] {ALIVE, INVULN, DEAD} role_state_t;
endpackage

// File: rtl/role_box_overlap.sv
// role_box_overlap: combinational axis-aligned overlap test of two WxW boxes
// Ports:
//   a_x_i, a_y_i  top-left corner of box A
//   b_x_i, b_y_i  top-left corner of box B
//   overlap_o     1 when the boxes share at least one pixel
// Sums are formed in 11 bits so x+W never wraps; a gap of exactly W
// (edges touching) is not an overlap.
module role_box_overlap #(
    parameter int W = 32
) (
    input  logic [9:0] a_x_i,
    input  logic [9:0] a_y_i,
    input  logic [9:0] b_x_i,
    input  logic [9:0] b_y_i,
    output logic       overlap_o
);
    localparam logic [10:0] W11 = 11'(W);
    logic [10:0] ax, ay, bx, by;
    always_comb begin
        ax = {1'b0, a_x_i};
        ay = {1'b0, a_y_i};
        bx = {1'b0, b_x_i};
        by = {1'b0, b_y_i};
        overlap_o = (ax < bx + W11) & (bx < ax + W11) & (ay < by + W11) & (by < ay + W11);
    end
endmodule

// File: rtl/role_collision_hp.sv
// role_collision_hp: player/enemy collision, hit points, invulnerability and difficulty feedback
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   jojo_x_i, jojo_y_i      player top-left position
//   enemy_x_i, enemy_y_i    enemy top-left position
//   enemy_valid_i           enemy active; no collisions when low
//   heal_i                  one-cycle pulse, +1 hp (ALIVE/INVULN only)
//   restart_i               one-cycle pulse, leaves DEAD with full hp
//   hp_o                    current hit points
//   hit_pulse_o             one cycle per counted hit
//   invuln_o                high while invulnerable
//   blink_o                 player sprite flash enable
//   game_over_o             high while dead
//   speed_offset_o          chase speed-up fed back to the enemy stage
// Build option: define COLLISION_GOD_MODE_EN to keep counting hits
// (pulse, speed step, invulnerability) without ever losing hp.
module role_collision_hp
    import role_pkg::role_state_t, role_pkg::ALIVE, role_pkg::INVULN, role_pkg::DEAD;
#(
    parameter int SPRITE_W      = 32,
    parameter int HP_MAX        = 5,
    parameter int INVULN_CYCLES = 50000000,
    parameter int SPEED_STEP    = 200000,
    parameter int SPEED_MAX     = 2000000,
    parameter int BLINK_BIT     = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  jojo_x_i,
    input  logic [9:0]  jojo_y_i,
    input  logic [9:0]  enemy_x_i,
    input  logic [9:0]  enemy_y_i,
    input  logic        enemy_valid_i,
    input  logic        heal_i,
    input  logic        restart_i,
    output logic [2:0]  hp_o,
    output logic        hit_pulse_o,
    output logic        invuln_o,
    output logic        blink_o,
    output logic        game_over_o,
    output logic [25:0] speed_offset_o
);
    localparam logic [2:0]  HP_FULL  = 3'(HP_MAX);
    localparam logic [25:0] CNT_LOAD = 26'(INVULN_CYCLES - 1);
    localparam logic [26:0] STEP     = 27'(SPEED_STEP);
    localparam logic [26:0] SMAX     = 27'(SPEED_MAX);

    role_state_t state_q, state_d;
    logic        box_hit, overlap_q, hit_q, hit_d;
    logic [2:0]  hp_q, hp_d, hp_inc;
    logic [25:0] spd_q, spd_d, spd_sat, cnt_q, cnt_d;
    logic [26:0] spd_sum;

    role_box_overlap #(.W(SPRITE_W)) u_box (
        .a_x_i     (jojo_x_i),
        .a_y_i     (jojo_y_i),
        .b_x_i     (enemy_x_i),
        .b_y_i     (enemy_y_i),
        .overlap_o (box_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ALIVE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overlap_q <= 1'b0;
            hit_q     <= 1'b0;
            hp_q      <= HP_FULL;
            spd_q     <= '0;
            cnt_q     <= '0;
        end else begin
            overlap_q <= enemy_valid_i & box_hit;
            hit_q     <= hit_d;
            hp_q      <= hp_d;
            spd_q     <= spd_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        spd_sum = {1'b0, spd_q} + STEP;
        spd_sat = (spd_sum > SMAX) ? SMAX[25:0] : spd_sum[25:0];
        hp_inc  = (hp_q >= HP_FULL) ? HP_FULL : hp_q + 3'd1;
    end

    // A counted hit takes priority over a heal arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        spd_d   = spd_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        case (state_q)
            ALIVE: begin
                if (overlap_q) begin
                    hit_d = 1'b1;
                    spd_d = spd_sat;
`ifdef COLLISION_GOD_MODE_EN
                    cnt_d   = CNT_LOAD;
                    state_d = INVULN;
`else
                    hp_d = hp_q - 3'd1;
                    if (hp_q > 3'd1) begin
                        cnt_d   = CNT_LOAD;
                        state_d = INVULN;
                    end else begin
                        state_d = DEAD;
                    end
`endif
                end else if (heal_i) begin
                    hp_d = hp_inc;
                end
            end
            INVULN: begin
                hp_d = heal_i ? hp_inc : hp_q;
                // Counter reaches 0 on the last invulnerable cycle, giving exactly INVULN_CYCLES cycles.
                if (cnt_q == '0) state_d = ALIVE;
                else             cnt_d = cnt_q - 26'd1;
            end
            DEAD: begin
                if (restart_i) begin
                    hp_d    = HP_FULL;
                    spd_d   = '0;
                    state_d = ALIVE;
                end
            end
            default: state_d = ALIVE;
        endcase
    end

    always_comb begin
        invuln_o       = (state_q == INVULN);
        game_over_o    = (state_q == DEAD);
        blink_o        = (state_q == INVULN) & cnt_q[BLINK_BIT];
        hp_o           = hp_q;
        hit_pulse_o    = hit_q;
        speed_offset_o = spd_q;
    end
endmodule

// File: tb/tb_role_collision_hp.sv
// tb_role_collision_hp: scoreboard bench for role_collision_hp (short invulnerability window)
module tb_role_collision_hp;
    localparam int HPM  = 5;
    localparam int IC   = 100;
    localparam int STEP = 200000;
    localparam int SMAX = 2000000;
`ifdef COLLISION_GOD_MODE_EN
    localparam bit GOD = 1'b1;
`else
    localparam bit GOD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  jojo_x = 10'd100, jojo_y = 10'd100, enemy_x = 10'd0, enemy_y = 10'd100;
    logic        enemy_valid = 1'b0, heal = 1'b0, restart = 1'b0;
    logic [2:0]  hp;
    logic        hit_pulse, invuln, blink, game_over;
    logic [25:0] speed_offset;

    int n_pass = 0;
    int n_total = 0;
    int exp_hp = HPM;
    int exp_spd = 0;
    bit exp_dead = 1'b0;
    logic [28:0] sb_q[$];

    role_collision_hp #(
        .HP_MAX        (HPM),
        .INVULN_CYCLES (IC),
        .BLINK_BIT     (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .jojo_x_i       (jojo_x),
        .jojo_y_i       (jojo_y),
        .enemy_x_i      (enemy_x),
        .enemy_y_i      (enemy_y),
        .enemy_valid_i  (enemy_valid),
        .heal_i         (heal),
        .restart_i      (restart),
        .hp_o           (hp),
        .hit_pulse_o    (hit_pulse),
        .invuln_o       (invuln),
        .blink_o        (blink),
        .game_over_o    (game_over),
        .speed_offset_o (speed_offset)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Every observed hit pulse is matched against the next expected {hp, speed_offset}.
    always @(negedge clk) begin
        logic [28:0] e;
        if (!reset && hit_pulse === 1'b1) begin
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_hit: got hit with hp=%0d spd=%0d, want no hit", hp, speed_offset);
            end else begin
                e = sb_q.pop_front();
                if ({hp, speed_offset} !== e)
                    $display("FAIL hit_sb: got hp=%0d spd=%0d, want hp=%0d spd=%0d", hp, speed_offset, e[28:26], e[25:0]);
                else
                    n_pass++;
            end
        end
    end

    task automatic model_hit();
        exp_spd = (exp_spd + STEP > SMAX) ? SMAX : exp_spd + STEP;
        if (!GOD) begin
            exp_hp--;
            exp_dead = (exp_hp == 0);
        end
        sb_q.push_back({3'(exp_hp), 26'(exp_spd)});
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_total++;
        if ({hp, speed_offset, hit_pulse, invuln, blink, game_over} !== {3'(HPM), 26'd0, 4'b0000})
            $display("FAIL reset: got hp=%0d spd=%0d hit=%b inv=%b blink=%b go=%b, want hp=%0d rest 0",
                     hp, speed_offset, hit_pulse, invuln, blink, game_over, HPM);
        else
            n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_hp = HPM;
        exp_spd = 0;
        exp_dead = 1'b0;
    endtask

    task automatic test_touch();
        int ex[4] = '{132, 68, 100, 131};
        int ey[4] = '{100, 100, 132, 100};
        bit ev[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic seen;
        for (int i = 0; i < 4; i++) begin
            enemy_x = 10'(ex[i]);
            enemy_y = 10'(ey[i]);
            enemy_valid = ev[i];
            seen = 1'b0;
            repeat (4) begin
                @(negedge clk);
                seen = seen | hit_pulse | invuln;
            end
            n_total++;
            if (seen !== 1'b0 || hp !== 3'(HPM))
                $display("FAIL no_overlap case %0d: got hit/inv seen=%b hp=%0d, want seen=0 hp=%0d", i, seen, hp, HPM);
            else
                n_pass++;
        end
    endtask

    task automatic test_first_hit(input int ex);
        int old_hp, old_spd;
        old_hp = exp_hp;
        old_spd = exp_spd;
        enemy_x = 10'(ex);
        enemy_y = 10'd100;
        enemy_valid = 1'b1;
        model_hit();
        @(negedge clk);
        n_total++;
        if ({hit_pulse, hp, speed_offset} !== {1'b0, 3'(old_hp), 26'(old_spd)})
            $display("FAIL hit_latency_early: got hit=%b hp=%0d spd=%0d, want hit=0 hp=%0d spd=%0d",
                     hit_pulse, hp, speed_offset, old_hp, old_spd);
        else
            n_pass++;
        @(negedge clk);
        n_total++;
        if ({hit_pulse, invuln, game_over, hp, speed_offset} !== {1'b1, !exp_dead, exp_dead, 3'(exp_hp), 26'(exp_spd)})
            $display("FAIL hit_latency: got hit=%b inv=%b go=%b hp=%0d spd=%0d, want hit=1 inv=%b go=%b hp=%0d spd=%0d",
                     hit_pulse, invuln, game_over, hp, speed_offset, !exp_dead, exp_dead, exp_hp, exp_spd);
        else
            n_pass++;
    endtask

    // Starts on the negedge that showed a hit; overlap is held so the next hit lands at j=101.
    task automatic invuln_window(input int h1, input int h2, input int r);
        int cnt;
        bit e_inv, e_blk;
        for (int j = 1; j <= 101; j++) begin
            heal = (j == h1 || j == h2);
            restart = (j == r);
            if (j == 101) model_hit();
            else if (heal) exp_hp = (exp_hp < HPM) ? exp_hp + 1 : HPM;
            @(negedge clk);
            heal = 1'b0;
            restart = 1'b0;
            cnt = 99 - j;
            e_inv = (j <= 99) || (j == 101 && !exp_dead);
            e_blk = (j <= 99) && cnt[3];
            n_total++;
            if ({hp, invuln, blink, game_over, hit_pulse, speed_offset} !==
                {3'(exp_hp), e_inv, e_blk, exp_dead, (j == 101), 26'(exp_spd)})
                $display("FAIL window j=%0d: got hp=%0d inv=%b blink=%b go=%b hit=%b spd=%0d, want hp=%0d inv=%b blink=%b go=%b hit=%b spd=%0d",
                         j, hp, invuln, blink, game_over, hit_pulse, speed_offset,
                         exp_hp, e_inv, e_blk, exp_dead, (j == 101), exp_spd);
            else
                n_pass++;
        end
    endtask

    task automatic test_invuln_windows();
        invuln_window(-1, -1, 50);
        invuln_window(101, -1, -1);
        invuln_window(5, -1, -1);
        invuln_window(-1, -1, -1);
        invuln_window(-1, -1, -1);
    endtask

    task automatic test_dead();
        for (int i = 0; i < 12; i++) begin
            heal = (i % 3 == 0);
            @(negedge clk);
            heal = 1'b0;
            n_total++;
            if ({hp, game_over, invuln, hit_pulse, speed_offset} !== {3'd0, 1'b1, 1'b0, 1'b0, 26'(exp_spd)})
                $display("FAIL dead_hold: got hp=%0d go=%b inv=%b hit=%b spd=%0d, want hp=0 go=1 inv=0 hit=0 spd=%0d",
                         hp, game_over, invuln, hit_pulse, speed_offset, exp_spd);
            else
                n_pass++;
        end
        enemy_valid = 1'b0;
        repeat (2) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        exp_hp = HPM;
        exp_spd = 0;
        exp_dead = 1'b0;
        n_total++;
        if ({hp, game_over, invuln, speed_offset} !== {3'(HPM), 1'b0, 1'b0, 26'd0})
            $display("FAIL restart: got hp=%0d go=%b inv=%b spd=%0d, want hp=%0d go=0 inv=0 spd=0",
                     hp, game_over, invuln, speed_offset, HPM);
        else
            n_pass++;
        repeat (5) begin
            @(negedge clk);
            n_total++;
            if ({hit_pulse, invuln, hp} !== {2'b00, 3'(HPM)})
                $display("FAIL valid_gate: got hit=%b inv=%b hp=%0d, want hit=0 inv=0 hp=%0d", hit_pulse, invuln, hp, HPM);
            else
                n_pass++;
        end
    endtask

    task automatic test_saturation();
        test_first_hit(131);
        repeat (10) invuln_window(10, 20, -1);
        n_total++;
        if (speed_offset !== 26'(SMAX))
            $display("FAIL speed_sat: got spd=%0d, want %0d", speed_offset, SMAX);
        else
            n_pass++;
    endtask

    task automatic test_async_reset();
        repeat (10) @(negedge clk);
        enemy_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({hp, speed_offset, hit_pulse, invuln, blink, game_over} !== {3'(HPM), 26'd0, 4'b0000})
            $display("FAIL async_reset: got hp=%0d spd=%0d hit=%b inv=%b blink=%b go=%b, want hp=%0d rest 0",
                     hp, speed_offset, hit_pulse, invuln, blink, game_over, HPM);
        else
            n_pass++;
        @(negedge clk);
        reset = 1'b0;
        exp_hp = HPM;
        exp_spd = 0;
        exp_dead = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if ({hit_pulse, invuln, game_over, hp} !== {3'b000, 3'(HPM)})
                $display("FAIL post_reset: got hit=%b inv=%b go=%b hp=%0d, want 0 0 0 hp=%0d",
                         hit_pulse, invuln, game_over, hp, HPM);
            else
                n_pass++;
        end
    endtask

    task automatic test_god_mode();
        test_first_hit(131);
        repeat (9) invuln_window(-1, -1, -1);
        n_total++;
        if ({hp, game_over} !== {3'(HPM), 1'b0})
            $display("FAIL god_mode: got hp=%0d go=%b, want hp=%0d go=0", hp, game_over, HPM);
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
`ifdef COLLISION_GOD_MODE_EN
        test_god_mode();
`else
        test_touch();
        test_first_hit(131);
        test_invuln_windows();
        test_dead();
        test_saturation();
        test_async_reset();
`endif
        n_total++;
        if (sb_q.size() != 0)
            $display("FAIL sb_drain: got %0d pending hits, want 0", sb_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
